eth_tx_frame_arbiter: RTL and testbench

// - Packet-level round-robin arbiter sharing the single MAC TX AXI-Stream byte port among N_PORTS frame sources.
// - Sits in the ETH_TX_AXIS_CLK domain in front of the MAC TX input (ETH_TX_AXIS_*); never splits or interleaves frames.
// - Enforces an idle gap between granted frames and optionally pads runt frames to the Ethernet minimum.

---
 rtl/eth_tx_frame_arbiter.sv | 160 ++++++++++++++++
 tb/tb_eth_tx_frame_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_tx_frame_arbiter.sv
// Packet-level round-robin arbiter sharing one MAC TX AXI-Stream byte port among N_PORTS frame sources.
// Optional runt padding to MIN_FRAME_LEN is compiled in when ETH_TX_ARB_PAD_EN is defined.
module eth_tx_frame_arbiter #(
    parameter int N_PORTS       = 2,
    parameter int GAP_CYCLES    = 2,
    parameter int MIN_FRAME_LEN = 60
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [N_PORTS*8-1:0] S_AXIS_TDATA,
    input  logic [N_PORTS-1:0]   S_AXIS_TVALID,
    input  logic [N_PORTS-1:0]   S_AXIS_TLAST,
    output logic [N_PORTS-1:0]   S_AXIS_TREADY,
    output logic [7:0]           M_AXIS_TDATA,
    output logic                 M_AXIS_TVALID,
    output logic                 M_AXIS_TLAST,
    input  logic                 M_AXIS_TREADY,
    output logic [N_PORTS-1:0]   GRANT,
    output logic                 BUSY
);
    // Handshake: a beat transfers on a cycle where TVALID and TREADY are both high; a source
    // holding TVALID keeps TDATA/TLAST stable until that beat, and TVALID never depends on TREADY.
    localparam int PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

`ifdef ETH_TX_ARB_PAD_EN
    typedef enum logic [1:0] {S_IDLE, S_DATA, S_GAP, S_PAD} state_t;
    localparam int CW = $clog2(MIN_FRAME_LEN + 1);
    localparam logic [CW-1:0] MIN_L   = CW'(MIN_FRAME_LEN);
    localparam logic [CW-1:0] CNT_MAX = '1;
    logic [CW-1:0] byte_cnt_q, byte_cnt_d, cnt_inc;
`else
    typedef enum logic [1:0] {S_IDLE, S_DATA, S_GAP} state_t;
`endif

    localparam state_t AFTER_FRAME = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;

    state_t        state_q, state_d;
    logic [PW-1:0] grant_idx_q, grant_idx_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic [PW-1:0] arb_idx;
    logic          arb_found;
    logic [7:0]    g_data;
    logic          g_valid, g_last;

    assign g_data  = S_AXIS_TDATA[8*grant_idx_q +: 8];
    assign g_valid = S_AXIS_TVALID[grant_idx_q];
    assign g_last  = S_AXIS_TLAST[grant_idx_q];
    assign BUSY    = (state_q != S_IDLE);

    // Search starts one past the last frame's owner so every requester gets its turn.
    always_comb begin
        logic [PW-1:0] cand;
        cand      = '0;
        arb_found = 1'b0;
        arb_idx   = ptr_q;
        for (int k = 1; k <= N_PORTS; k++) begin
            cand = PW'((int'(ptr_q) + k) % N_PORTS);
            if (!arb_found && S_AXIS_TVALID[cand]) begin
                arb_found = 1'b1;
                arb_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_idx_d   = grant_idx_q;
        ptr_d         = ptr_q;
        gap_cnt_d     = gap_cnt_q;
        S_AXIS_TREADY = '0;
        M_AXIS_TDATA  = 8'h00;
        M_AXIS_TVALID = 1'b0;
        M_AXIS_TLAST  = 1'b0;
        GRANT         = '0;
`ifdef ETH_TX_ARB_PAD_EN
        byte_cnt_d = byte_cnt_q;
        cnt_inc    = (byte_cnt_q == CNT_MAX) ? byte_cnt_q : byte_cnt_q + CW'(1);
`endif
        case (state_q)
            S_IDLE: begin
`ifdef ETH_TX_ARB_PAD_EN
                byte_cnt_d = '0;
`endif
                if (arb_found) begin
                    grant_idx_d = arb_idx;
                    state_d     = S_DATA;
                end
            end
            S_DATA: begin
                GRANT[grant_idx_q]         = 1'b1;
                S_AXIS_TREADY[grant_idx_q] = M_AXIS_TREADY;
                M_AXIS_TDATA               = g_data;
                M_AXIS_TVALID              = g_valid;
                M_AXIS_TLAST               = g_valid & g_last;
                if (g_valid && M_AXIS_TREADY) begin
`ifdef ETH_TX_ARB_PAD_EN
                    byte_cnt_d = cnt_inc;
`endif
                    if (g_last) begin
                        ptr_d     = grant_idx_q;
                        gap_cnt_d = '0;
                        state_d   = AFTER_FRAME;
`ifdef ETH_TX_ARB_PAD_EN
                        // Runt: the source's last byte goes out unterminated and zeros follow.
                        if (cnt_inc < MIN_L) begin
                            M_AXIS_TLAST = 1'b0;
                            state_d      = S_PAD;
                        end
`endif
                    end
                end
            end
`ifdef ETH_TX_ARB_PAD_EN
            S_PAD: begin
                GRANT[grant_idx_q] = 1'b1;
                M_AXIS_TVALID      = 1'b1;
                M_AXIS_TLAST       = (cnt_inc >= MIN_L);
                if (M_AXIS_TREADY) begin
                    byte_cnt_d = cnt_inc;
                    if (cnt_inc >= MIN_L) begin
                        state_d = AFTER_FRAME;
                    end
                end
            end
`endif
            S_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= S_IDLE;
            grant_idx_q <= '0;
            ptr_q       <= PW'(N_PORTS - 1);
            gap_cnt_q   <= '0;
`ifdef ETH_TX_ARB_PAD_EN
            byte_cnt_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            grant_idx_q <= grant_idx_d;
            ptr_q       <= ptr_d;
            gap_cnt_q   <= gap_cnt_d;
`ifdef ETH_TX_ARB_PAD_EN
            byte_cnt_q  <= byte_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_eth_tx_frame_arbiter.sv
// Self-checking bench for eth_tx_frame_arbiter: per-port frame sources, frame-level round-robin
// reference model producing the expected output byte stream, and immediate-assertion checks.
module tb_eth_tx_frame_arbiter;
  localparam int N = 2;
  localparam int GAP = 2;
  localparam int MIN_LEN = 60;

  logic           clk = 1'b0;
  logic           rst;
  logic [N*8-1:0] s_tdata;
  logic [N-1:0]   s_tvalid, s_tlast, s_tready;
  logic [7:0]     m_tdata;
  logic           m_tvalid, m_tlast, m_tready;
  logic [N-1:0]   grant;
  logic           busy;

  eth_tx_frame_arbiter #(.N_PORTS(N), .GAP_CYCLES(GAP), .MIN_FRAME_LEN(MIN_LEN)) dut (
    .CLK(clk), .RESET(rst),
    .S_AXIS_TDATA(s_tdata), .S_AXIS_TVALID(s_tvalid), .S_AXIS_TLAST(s_tlast),
    .S_AXIS_TREADY(s_tready),
    .M_AXIS_TDATA(m_tdata), .M_AXIS_TVALID(m_tvalid), .M_AXIS_TLAST(m_tlast),
    .M_AXIS_TREADY(m_tready),
    .GRANT(grant), .BUSY(busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- bench state ----------------
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int beats = 0;
  int rdy_mode = 0;      // 0: always ready, 1: toggle, 2: random
  int last_port = N - 1; // model of the round-robin owner of the previous frame
  bit gap_track = 1'b0;
  int gap_cnt = 0;

  logic [8:0]  src_q [N][$];  // {last, data} beats still to be offered by each source
  int          m_len [N][$];  // model copy: frame lengths per port
  logic [7:0]  m_dat [N][$];  // model copy: frame bytes per port
  logic [11:0] exp_q [$];     // {port[2:0], last, data} expected output beats

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic add_frame(input int p, input int len, input int base);
    logic [7:0] d;
    for (int i = 0; i < len; i++) begin
      d = (base < 0) ? 8'($urandom) : 8'(base + i);
      src_q[p].push_back({(i == len - 1), d});
      m_dat[p].push_back(d);
    end
    m_len[p].push_back(len);
  endtask

  // Frame-level model: frames leave whole, owners rotate among ports that still have frames.
  task automatic build_expected();
    int pick, len, total, c;
    logic [7:0] d;
    while (1) begin
      pick = -1;
      for (int k = 1; k <= N; k++) begin
        c = (last_port + k) % N;
        if (pick < 0 && m_len[c].size() > 0) pick = c;
      end
      if (pick < 0) break;
      len = m_len[pick].pop_front();
      total = len;
`ifdef ETH_TX_ARB_PAD_EN
      if (len < MIN_LEN) total = MIN_LEN;
`endif
      for (int i = 0; i < total; i++) begin
        d = (i < len) ? m_dat[pick].pop_front() : 8'h00;
        exp_q.push_back({3'(pick), (i == total - 1), d});
      end
      last_port = pick;
    end
  endtask

  task automatic tick();
    logic [11:0]  e;
    logic [N-1:0] eg;
    bit           pending;
    @(negedge clk);
    for (int p = 0; p < N; p++) begin
      if (src_q[p].size() > 0) begin
        s_tvalid[p] = 1'b1;
        s_tlast[p] = src_q[p][0][8];
        s_tdata[8*p +: 8] = src_q[p][0][7:0];
      end else begin
        s_tvalid[p] = 1'b0;
        s_tlast[p] = 1'b0;
        s_tdata[8*p +: 8] = 8'h00;
      end
    end
    case (rdy_mode)
      0: m_tready = 1'b1;
      1: m_tready = (cyc % 2 == 0);
      default: m_tready = ($urandom_range(0, 3) != 0);
    endcase
    #1;
    chk("tready_only_granted", 32'(s_tready & ~grant), 0);
    if (gap_track) begin
      gap_cnt++;
      if (gap_cnt < GAP + 2) begin
        chk("gap_grant_zero", 32'(grant), 0);
        chk("gap_tvalid_zero", 32'(m_tvalid), 0);
      end else begin
        pending = 1'b0;
        for (int p = 0; p < N; p++) if (src_q[p].size() > 0) pending = 1'b1;
        if (pending) chk("regrant_after_gap", 32'(grant != '0), 1);
        gap_track = 1'b0;
      end
    end
    if (m_tvalid && m_tready) begin
      beats++;
      chk("beat_expected", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        eg = N'(1) << e[11:9];
        chk("beat_data", 32'(m_tdata), 32'(e[7:0]));
        chk("beat_last", 32'(m_tlast), 32'(e[8]));
        chk("beat_grant", 32'(grant), 32'(eg));
        chk("beat_busy", 32'(busy), 1);
      end
      if (m_tlast) begin
        gap_track = 1'b1;
        gap_cnt = 0;
      end
    end
    for (int p = 0; p < N; p++) begin
      if (s_tready[p] && s_tvalid[p] && src_q[p].size() > 0) void'(src_q[p].pop_front());
    end
    cyc++;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      tick();
      n++;
    end
    chk("drain_timeout_left", 32'(exp_q.size()), 0);
    repeat (GAP + 3) tick();
    gap_track = 1'b0;
    chk("idle_busy", 32'(busy), 0);
    chk("idle_grant", 32'(grant), 0);
    exp_q.delete();
    for (int p = 0; p < N; p++) src_q[p].delete();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    rst = 1'b1;
    s_tdata = '0;
    s_tvalid = '0;
    s_tlast = '0;
    m_tready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_grant", 32'(grant), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_s_tready", 32'(s_tready), 0);
    chk("rst_m_tvalid", 32'(m_tvalid), 0);
    chk("rst_m_tlast", 32'(m_tlast), 0);
    chk("rst_m_tdata", 32'(m_tdata), 0);
    rst = 1'b0;

    // 64-byte frame on port 0 with the MAC always ready
    rdy_mode = 0;
    add_frame(0, 64, -1);
    build_expected();
    drain(400);

    // both ports continuously requesting, three frames each
    for (int f = 0; f < 3; f++) begin
      add_frame(0, $urandom_range(1, 20), -1);
      add_frame(1, $urandom_range(1, 20), -1);
    end
    build_expected();
    drain(1000);

    // MAC ready toggling every cycle, 10-byte frame 0x01..0x0A
    rdy_mode = 1;
    add_frame(0, 10, 1);
    build_expected();
    drain(400);

    // 20-byte runt frame (padded only when padding is compiled in)
    rdy_mode = 0;
    add_frame(0, 20, -1);
    build_expected();
    drain(400);

    // reset on beat 5 of a 30-byte frame from port 1
    add_frame(1, 30, 8'h40);
    build_expected();
    beats = 0;
    n = 0;
    while (beats < 5 && n < 100) begin
      tick();
      n++;
    end
    chk("reached_beat5", 32'(beats), 5);
    @(negedge clk);
    rst = 1'b1;
    s_tvalid = '0;
    s_tlast = '0;
    @(negedge clk);
    #1;
    chk("midrst_m_tvalid", 32'(m_tvalid), 0);
    chk("midrst_m_tlast", 32'(m_tlast), 0);
    chk("midrst_m_tdata", 32'(m_tdata), 0);
    chk("midrst_grant", 32'(grant), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_s_tready", 32'(s_tready), 0);
    exp_q.delete();
    for (int p = 0; p < N; p++) begin
      src_q[p].delete();
      m_len[p].delete();
      m_dat[p].delete();
    end
    last_port = N - 1;
    gap_track = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    add_frame(1, 8, -1);
    add_frame(0, 8, -1);
    build_expected();
    drain(400);

    // single-byte frame on port 1
    add_frame(1, 1, 8'hA5);
    build_expected();
    drain(200);

    // randomized rounds with random MAC back-pressure
    rdy_mode = 2;
    for (int r = 0; r < 8; r++) begin
      for (int p = 0; p < N; p++) begin
        n = $urandom_range(0, 3);
        for (int f = 0; f < n; f++) add_frame(p, $urandom_range(1, 70), -1);
      end
      build_expected();
      drain(3000);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
